// File: rtl/isp_pkg.sv
// Shared types and constants for the streaming auto-exposure engine.
// The optional saturation counter is controlled by the macro ISP_EXPO_SATCNT_EN.
package isp_pkg;

    // Pixel ratio applied to every lane of a beat.
    typedef enum logic [1:0] {
        RATIO_Q = 2'd0,   // >>2
        RATIO_H = 2'd1,   // >>1
        RATIO_1 = 2'd2,   // x1
        RATIO_2 = 2'd3    // x2, saturating at 255
    } ratio_mode_e;

    // Engine FSM states. These are plain constants so older tooling can use them.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Gray weights are right shifts of the scaled pixel, one for each plane.
    localparam int GRAY_SH_R = 2;
    localparam int GRAY_SH_G = 1;
    localparam int GRAY_SH_B = 2;

    // Ceiling log2 for use in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/isp_expo_stream_scale.sv
// Combinational scaler for one beat: applies the ratio to each lane and
// sums the lanes' gray contributions for the current plane.
// With ISP_EXPO_SATCNT_EN defined it also counts the lanes that were clipped.
module isp_pix_scale
    import isp_pkg::*;
#(
    parameter int BEAT_PIX = 16,
    parameter int CH_W     = 2,
    parameter int GSUM_W   = 8 + clog2(BEAT_PIX)
) (
    input  ratio_mode_e               ratio_mode,
    input  logic [CH_W-1:0]           ch,
    input  logic [BEAT_PIX*8-1:0]     pix_in,
    output logic [BEAT_PIX*8-1:0]     pix_out,
    output logic [GSUM_W-1:0]         gray_sum
`ifdef ISP_EXPO_SATCNT_EN
    ,
    output logic [clog2(BEAT_PIX):0]  sat_lanes
`endif
);

    localparam logic [CH_W-1:0] CH_R = CH_W'(0);
    localparam logic [CH_W-1:0] CH_G = CH_W'(1);

    logic [BEAT_PIX-1:0]      clip;
    logic [BEAT_PIX-1:0][7:0] wgt;

    for (genvar l = 0; l < BEAT_PIX; l++) begin : g_lane
        logic [8:0] prod;
        logic [7:0] scaled;

        // Scale one lane; the x2 product keeps its carry so it can be clipped.
        always_comb begin
            case (ratio_mode)
                RATIO_Q: prod = {3'b000, pix_in[8*l+2 +: 6]};
                RATIO_H: prod = {2'b00,  pix_in[8*l+1 +: 7]};
                RATIO_1: prod = {1'b0,   pix_in[8*l   +: 8]};
                default: prod = {pix_in[8*l +: 8], 1'b0};
            endcase
        end

        assign clip[l]            = prod[8];
        assign scaled             = prod[8] ? 8'hFF : prod[7:0];
        assign pix_out[8*l +: 8]  = scaled;
        assign wgt[l]             = (ch == CH_G) ? (scaled >> GRAY_SH_G) :
                                    (ch == CH_R) ? (scaled >> GRAY_SH_R) :
                                                   (scaled >> GRAY_SH_B);
    end

    // Adder tree over the weighted lanes of this beat.
    always_comb begin
        gray_sum = '0;
        for (int l = 0; l < BEAT_PIX; l++) begin
            gray_sum = gray_sum + GSUM_W'(wgt[l]);
        end
    end

`ifdef ISP_EXPO_SATCNT_EN
    // Count the lanes that saturated in this beat.
    always_comb begin
        sat_lanes = '0;
        for (int l = 0; l < BEAT_PIX; l++) begin
            sat_lanes = sat_lanes + (clog2(BEAT_PIX) + 1)'(clip[l]);
        end
    end
`endif

endmodule

// File: rtl/isp_expo_stream.sv
// Streaming auto-exposure engine. It scales one picture of R, G, B planes,
// returns the scaled beats for write-back, and reports the weighted gray mean.
// When ISP_EXPO_SATCNT_EN is defined the engine adds the sat_cnt output.
//
// Handshake: a beat moves on a stream in any cycle where valid and ready are
// both high at the clock edge. A producer keeps valid and data stable until
// that transfer happens. in_ready depends only on the engine state and on wb_ready.
module isp_expo_stream
    import isp_pkg::*;
#(
    parameter int IMG_DIM  = 32,
    parameter int BEAT_PIX = 16,
    parameter int NUM_CH   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [1:0]                 ratio_mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BEAT_PIX*8-1:0]      in_data,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [BEAT_PIX*8-1:0]      wb_data,
    output logic                       done,
    output logic [7:0]                 mean,
    output logic                       busy,
`ifdef ISP_EXPO_SATCNT_EN
    output logic [2*clog2(IMG_DIM)+1:0] sat_cnt,
`endif
    output logic [1:0]                 fsm_state
);

    localparam int LOG_DIM      = clog2(IMG_DIM);
    localparam int BEATS_PER_CH = IMG_DIM * IMG_DIM / BEAT_PIX;
    localparam int BEAT_W       = (clog2(BEATS_PER_CH) > 0) ? clog2(BEATS_PER_CH) : 1;
    localparam int CH_W         = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1;
    localparam int SUM_W        = 8 + 2 * LOG_DIM;
    localparam int GSUM_W       = 8 + clog2(BEAT_PIX);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_CH - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

    logic [1:0]              state;
    ratio_mode_e             mode;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [CH_W-1:0]         ch_cnt;
    logic [SUM_W-1:0]        acc;
    logic [BEAT_PIX*8-1:0]   scaled;
    logic [GSUM_W-1:0]       gray_sum;
    logic                    accept;
`ifdef ISP_EXPO_SATCNT_EN
    logic [clog2(BEAT_PIX):0] sat_lanes;
`endif

    assign fsm_state = state;
    // There is a single output register, so a new beat can enter whenever that register frees up in the same cycle.
    assign in_ready  = (state == RUN) && (!wb_valid || wb_ready);
    assign accept    = in_valid && in_ready;

    isp_pix_scale #(
        .BEAT_PIX (BEAT_PIX),
        .CH_W     (CH_W),
        .GSUM_W   (GSUM_W)
    ) u_scale (
        .ratio_mode (mode),
        .ch         (ch_cnt),
        .pix_in     (in_data),
        .pix_out    (scaled),
        .gray_sum   (gray_sum)
`ifdef ISP_EXPO_SATCNT_EN
        ,
        .sat_lanes  (sat_lanes)
`endif
    );

    // Picture sequencing, output register, and the gray accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode     <= RATIO_Q;
            beat_cnt <= '0;
            ch_cnt   <= '0;
            acc      <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            done     <= 1'b0;
            mean     <= '0;
            busy     <= 1'b0;
`ifdef ISP_EXPO_SATCNT_EN
            sat_cnt  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode     <= ratio_mode_e'(ratio_mode);
                        acc      <= '0;
                        beat_cnt <= '0;
                        ch_cnt   <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
`ifdef ISP_EXPO_SATCNT_EN
                        sat_cnt  <= '0;
`endif
                    end
                end
                RUN: begin
                    if (accept) begin
                        wb_data  <= scaled;
                        wb_valid <= 1'b1;
                        acc      <= acc + SUM_W'(gray_sum);
`ifdef ISP_EXPO_SATCNT_EN
                        sat_cnt  <= sat_cnt + ($bits(sat_cnt))'(sat_lanes);
`endif
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            if (ch_cnt == LAST_CH) begin
                                state <= DRAIN;
                            end else begin
                                ch_cnt <= ch_cnt + CH_W'(1);
                            end
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end else if (wb_ready) begin
                        wb_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    // The mean becomes valid together with done, one cycle after the last write-back beat.
                    if (wb_valid && wb_ready) begin
                        wb_valid <= 1'b0;
                        mean     <= acc[SUM_W-1 -: 8];
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_isp_expo_stream.sv
// Self-checking bench for isp_expo_stream. It exercises a default-size
// instance and a 16x16 / 8-pixel-beat instance against a pixel-level model.
module tb_isp_expo_stream;
    import isp_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, in_valid, wb_ready, sel;
    logic [1:0]   ratio;
    logic [127:0] in_data;

    logic         a_in_ready, a_wb_valid, a_done, a_busy;
    logic [127:0] a_wb_data;
    logic [7:0]   a_mean;
    logic [1:0]   a_state;
    logic         b_in_ready, b_wb_valid, b_done, b_busy;
    logic [63:0]  b_wb_data;
    logic [7:0]   b_mean;
    logic [1:0]   b_state;
`ifdef ISP_EXPO_SATCNT_EN
    logic [11:0]  a_sat;
    logic [9:0]   b_sat;
`endif

    isp_expo_stream u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start && !sel), .ratio_mode(ratio),
        .in_valid(in_valid && !sel), .in_ready(a_in_ready), .in_data(in_data),
        .wb_valid(a_wb_valid), .wb_ready(wb_ready), .wb_data(a_wb_data),
        .done(a_done), .mean(a_mean), .busy(a_busy),
`ifdef ISP_EXPO_SATCNT_EN
        .sat_cnt(a_sat),
`endif
        .fsm_state(a_state)
    );

    isp_expo_stream #(.IMG_DIM(16), .BEAT_PIX(8), .NUM_CH(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start && sel), .ratio_mode(ratio),
        .in_valid(in_valid && sel), .in_ready(b_in_ready), .in_data(in_data[63:0]),
        .wb_valid(b_wb_valid), .wb_ready(wb_ready), .wb_data(b_wb_data),
        .done(b_done), .mean(b_mean), .busy(b_busy),
`ifdef ISP_EXPO_SATCNT_EN
        .sat_cnt(b_sat),
`endif
        .fsm_state(b_state)
    );

    // The instance currently under test
    logic         cur_in_ready, cur_wb_valid, cur_done, cur_busy;
    logic [127:0] cur_wb_data;
    logic [7:0]   cur_mean;
    logic [1:0]   cur_state;
    assign cur_in_ready = sel ? b_in_ready : a_in_ready;
    assign cur_wb_valid = sel ? b_wb_valid : a_wb_valid;
    assign cur_done     = sel ? b_done     : a_done;
    assign cur_busy     = sel ? b_busy     : a_busy;
    assign cur_wb_data  = sel ? {64'b0, b_wb_data} : a_wb_data;
    assign cur_mean     = sel ? b_mean     : a_mean;
    assign cur_state    = sel ? b_state    : a_state;
`ifdef ISP_EXPO_SATCNT_EN
    logic [11:0]  cur_sat;
    assign cur_sat = sel ? {2'b0, b_sat} : a_sat;
`endif

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference scaling from the ratio definitions
    function automatic int scale_ref(input int m, input int px);
        case (m)
            0:       return px / 4;
            1:       return px / 2;
            2:       return px;
            default: return (2 * px > 255) ? 255 : 2 * px;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_start(input int m);
        @(negedge clk);
        check("in_ready_idle", cur_in_ready, 0);
        ratio = 2'(m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ratio = 2'($urandom_range(0, 3));   // must not matter after start
        check("busy_after_start", cur_busy, 1);
    endtask

    // kind 0 = constant pixel value, kind 1 = random pixels
    task automatic run_picture(input bit s, input int m, input int kind, input int val,
                               input bit stall, input bit poke);
        int n_beats, bp, plane_px, gray_total, sat_total, exp_mean;
        int drv_cycles, got, done_early;
        logic [127:0] beats[$];
        logic [127:0] beat, exp_beat;

        sel        = s;
        n_beats    = s ? 96 : 192;
        bp         = s ? 8 : 16;
        plane_px   = s ? 256 : 1024;
        gray_total = 0;
        sat_total  = 0;
        exp_q.delete();
        for (int b = 0; b < n_beats; b++) begin
            int ch;
            ch       = b / (n_beats / 3);
            beat     = '0;
            exp_beat = '0;
            for (int p = 0; p < bp; p++) begin
                int px, sc;
                px = kind ? int'($urandom_range(0, 255)) : val;
                sc = scale_ref(m, px);
                beat[8*p +: 8]     = 8'(px);
                exp_beat[8*p +: 8] = 8'(sc);
                gray_total += (ch == 1) ? sc / 2 : sc / 4;
                if (m == 3 && 2 * px > 255) sat_total++;
            end
            beats.push_back(beat);
            exp_q.push_back(exp_beat);
        end
        exp_mean = gray_total / plane_px;

        do_start(m);
        drv_cycles = 0;
        got        = 0;
        done_early = 0;
        fork
            begin : driver
                int  b;
                bit  poked;
                b     = 0;
                poked = 0;
                while (b < n_beats && drv_cycles < 4000) begin
                    bit hs;
                    @(negedge clk);
                    if (poke && b == 10 && !poked) begin
                        start = 1'b1;
                        ratio = 2'd3;
                        poked = 1;
                    end else begin
                        start = 1'b0;
                    end
                    in_valid = 1'b1;
                    in_data  = beats[b];
                    #3;
                    hs = cur_in_ready;
                    @(posedge clk);
                    if (hs) b++;
                    drv_cycles++;
                end
                @(negedge clk);
                in_valid = 1'b0;
                start    = 1'b0;
            end
            begin : monitor
                int cyc, stall_left;
                cyc        = 0;
                stall_left = 0;
                while (got < n_beats && cyc < 4000) begin
                    @(negedge clk);
                    wb_ready = (stall_left == 0);
                    #3;
                    if (cur_done) done_early++;
                    if (!wb_ready && cur_wb_valid) check("in_ready_stall", cur_in_ready, 0);
                    if (cur_wb_valid && wb_ready) begin
                        check("wb_data", cur_wb_data, exp_q.pop_front());
                        got++;
                        if (stall && (got % 20) == 0) stall_left = 5;
                    end else if (stall_left > 0) begin
                        stall_left--;
                    end
                    @(posedge clk);
                    cyc++;
                end
                // The last write-back handshake happened at the previous edge
                #1;
                check("done_pulse", cur_done, 1);
                check("mean", cur_mean, exp_mean);
                check("busy_at_done", cur_busy, 1);
`ifdef ISP_EXPO_SATCNT_EN
                check("sat_cnt", cur_sat, sat_total);
`endif
                @(posedge clk);
                #1;
                check("done_one_cycle", cur_done, 0);
                check("busy_dropped", cur_busy, 0);
                check("state_idle", cur_state, IDLE);
                check("wb_valid_clear", cur_wb_valid, 0);
                check("mean_held", cur_mean, exp_mean);
            end
        join
        check("wb_beat_count", got, n_beats);
        check("no_early_done", done_early, 0);
        if (!stall) check("full_throughput", drv_cycles, n_beats);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready",  {a_in_ready, b_in_ready}, 0);
        check("rst_wb_valid",  {a_wb_valid, b_wb_valid}, 0);
        check("rst_wb_data_a", a_wb_data, 0);
        check("rst_wb_data_b", b_wb_data, 0);
        check("rst_done",      {a_done, b_done}, 0);
        check("rst_mean",      {a_mean, b_mean}, 0);
        check("rst_busy",      {a_busy, b_busy}, 0);
        check("rst_state",     {a_state, b_state}, {IDLE, IDLE});
`ifdef ISP_EXPO_SATCNT_EN
        check("rst_sat",       {a_sat, b_sat}, 0);
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int dones;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        wb_ready = 1'b1;
        sel      = 1'b0;
        ratio    = 2'd0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;

        // Pass-through, quarter scaling, saturating x2
        run_picture(0, 2, 0, 8'h80, 0, 0);
        run_picture(0, 0, 0, 8'h80, 0, 0);
        run_picture(0, 3, 0, 8'hC0, 0, 0);
        // Random data with write-back stalls
        run_picture(0, 1, 1, 0, 1, 0);
        run_picture(0, 3, 1, 0, 1, 0);

        // Abort mid-picture with reset
        sel = 1'b0;
        do_start(1);
        wb_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (a_done) dones++;
        end
        check("no_done_after_abort", dones, 0);
        run_picture(0, 1, 0, 8'h01, 0, 0);

        // Small configuration, start pulses during RUN must be ignored
        run_picture(1, 2, 0, 8'h40, 0, 1);
        run_picture(1, 0, 1, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/isp_expo_stream.md
Name: isp_expo_stream

Overview:
- Streaming auto-exposure engine for the ISP datapath; a parametrised successor to the fixed 32x32, 3-plane exposure function.
- Takes one picture's pixel beats from the DRAM read path in plane order R, G, B. Scales each pixel by the ratio mode and returns the scaled beats for DRAM write-back.
- Accumulates the weighted gray sum (R>>2 + G>>1 + B>>2) of the scaled pixels and reports the mean at end of picture.
- Adds beyond the fixed version: configurable image size and beat width, x2 ratio with saturation, and ready/valid backpressure on both streams.

Parameters:
- IMG_DIM, 32, image side length in pixels; power of two, 8..128.
- BEAT_PIX, 16, pixels per beat (8-bit each); power of two; divides IMG_DIM*IMG_DIM.
- NUM_CH, 3, planes per picture; fixed R, G, B order; gray weights are defined for 3 only.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse in IDLE: begin a picture
- ratio_mode  in  2  sampled on start: 0 = >>2, 1 = >>1, 2 = x1, 3 = x2 saturating at 255
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts beat
- in_data  in  BEAT_PIX*8  pixels; pixel p at bits [8p+7:8p], p=0 is lowest address
- wb_valid  out  1  scaled beat valid
- wb_ready  in  1  write-back path accepts beat
- wb_data  out  BEAT_PIX*8  scaled pixels, same lane order as in_data
- done  out  1  one-cycle pulse: mean valid
- mean  out  8  exposure mean, held until next start
- busy  out  1  high from accepted start until done

Behaviour:
- Reset values: in_ready=0, wb_valid=0, wb_data=0, done=0, mean=0, busy=0; FSM=IDLE; counters and accumulator cleared.
- Constants: BEATS_PER_CH = IMG_DIM*IMG_DIM/BEAT_PIX; SUM_W = 8 + 2*log2(IMG_DIM).
- IDLE: in_ready=0. On start: latch ratio_mode; clear accumulator, beat counter and channel counter; go to RUN. Cycle after start: busy=1.
- RUN:
  - in_ready = !wb_valid || wb_ready (single output register, no bubbles).
  - On in_valid && in_ready: register scaled beat into wb_data and set wb_valid. Add the per-lane weighted sum into the accumulator (R and B planes >>2, G plane >>1, applied to the scaled value). Advance counters.
  - wb_valid clears on wb_ready with no new beat.
  - After the last beat of the last channel is accepted, go to DRAIN.
- DRAIN: in_ready=0; wait until the final wb beat is accepted (wb_valid && wb_ready), then go to DONE.
- DONE (one cycle): mean = accumulator[SUM_W-1 : 2*log2(IMG_DIM)] (truncation); done=1; busy drops next cycle; return to IDLE.
- Latency:
  - First wb beat is 1 cycle after its input handshake.
  - done is 1 cycle after the final wb handshake.
  - Full throughput is 1 beat/cycle with wb_ready held high.
- Scaling arithmetic: mode 3 uses a 9-bit product; bit 8 set forces 255. Modes 0/1 shift in zeros.
- Boundaries:
  - start outside IDLE is ignored.
  - in_valid in IDLE/DRAIN/DONE is ignored (in_ready=0).
  - Counters wrap the beat index at BEATS_PER_CH-1 and increment the channel; the last beat is channel NUM_CH-1, beat BEATS_PER_CH-1.
  - Simultaneous wb handshake and new input beat: the new beat replaces the register and wb_valid stays 1.
  - rst_n low mid-picture: immediate return to reset values; the partial picture is discarded and no done is issued.
  - Accumulator cannot overflow at SUM_W (max gray 253 per pixel).

Optional Feature:
- Macro: ISP_EXPO_SATCNT_EN.
- Defined: adds output port sat_cnt, width 2*log2(IMG_DIM)+2. It counts pixels clipped in mode 3, clears on start, and is valid with done.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package isp_pkg:
  - ratio_mode enum (RATIO_Q, RATIO_H, RATIO_1, RATIO_2)
  - FSM state enum (IDLE, RUN, DRAIN, DONE)
  - gray weight shift constants (R=2, G=1, B=2)
  - clog2 helper
- One natural sub-module, isp_pix_scale: combinational per-lane scaler plus weighted-gray adder tree for one beat. It is instantiated once and takes ratio_mode and the channel index.

Test Plan:
- All pixels 0x80, mode 2, wb_ready=1 → wb_data equals in_data; mean=128; done exactly 1 cycle after the 192nd wb beat (default params).
- All 0x80, mode 0 → every wb pixel 0x20; mean=32.
- All 0xC0, mode 3 → every wb pixel 0xFF; mean=253; with ISP_EXPO_SATCNT_EN, sat_cnt=3072.
- Random data, mode 1, wb_ready low 5 cycles every 20 beats → in_ready low during stalls; no beat lost or duplicated; mean matches the model computed over scaled pixels.
- rst_n pulsed at beat 100, then new start with all 0x01, mode 1 → no done from the aborted run; wb pixels 0x00; mean=0.
- IMG_DIM=16, BEAT_PIX=8, all 0x40, mode 2 → 96 beats; mean=64; start pulses during RUN are ignored.
